// File: rtl/mp3_sine_gen.sv
// Free-running 512-sample sine generator for a 10-bit resistor-ladder DAC, rebuilt from a quarter-wave ROM.
// Optional build macro MP3_OUTPUT_INVERT_EN drives the complemented word for an inverting ladder buffer.
module mp3_sine_gen #(
  parameter int SAMPLE_DIV = 1,
  parameter int PHASE_INC  = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic _9b,
  output logic _6a,
  output logic _4a,
  output logic _2a,
  output logic _0a,
  output logic _5a,
  output logic _3b,
  output logic _49a,
  output logic _45a,
  output logic _48b
);

  // Q[i] = min(511, floor(512*sin(pi*(2i+1)/512))), sampled at odd half-steps so the
  // four quadrants mirror exactly about 511.5 with no repeated sample at the seams.
  localparam logic [8:0] QUARTER_ROM [128] = '{
    9'd3,   9'd9,   9'd15,  9'd21,  9'd28,  9'd34,  9'd40,  9'd47,
    9'd53,  9'd59,  9'd65,  9'd72,  9'd78,  9'd84,  9'd90,  9'd96,
    9'd102, 9'd109, 9'd115, 9'd121, 9'd127, 9'd133, 9'd139, 9'd145,
    9'd151, 9'd157, 9'd163, 9'd169, 9'd175, 9'd181, 9'd187, 9'd193,
    9'd198, 9'd204, 9'd210, 9'd216, 9'd221, 9'd227, 9'd233, 9'd238,
    9'd244, 9'd249, 9'd255, 9'd260, 9'd265, 9'd271, 9'd276, 9'd281,
    9'd287, 9'd292, 9'd297, 9'd302, 9'd307, 9'd312, 9'd317, 9'd322,
    9'd327, 9'd332, 9'd336, 9'd341, 9'd346, 9'd350, 9'd355, 9'd359,
    9'd364, 9'd368, 9'd372, 9'd377, 9'd381, 9'd385, 9'd389, 9'd393,
    9'd397, 9'd401, 9'd405, 9'd409, 9'd413, 9'd416, 9'd420, 9'd423,
    9'd427, 9'd430, 9'd434, 9'd437, 9'd440, 9'd443, 9'd447, 9'd450,
    9'd453, 9'd455, 9'd458, 9'd461, 9'd464, 9'd466, 9'd469, 9'd471,
    9'd474, 9'd476, 9'd478, 9'd481, 9'd483, 9'd485, 9'd487, 9'd489,
    9'd490, 9'd492, 9'd494, 9'd495, 9'd497, 9'd498, 9'd500, 9'd501,
    9'd502, 9'd503, 9'd504, 9'd505, 9'd506, 9'd507, 9'd508, 9'd509,
    9'd509, 9'd510, 9'd510, 9'd511, 9'd511, 9'd511, 9'd511, 9'd511
  };

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [8:0]  N_STEP   = 9'(PHASE_INC);

  logic [15:0] div_reg,  div_next;
  logic [8:0]  n_reg,    n_next;
  logic [9:0]  dac_reg,  dac_next;
  logic [1:0]  quadrant;
  logic [6:0]  rom_addr;
  logic [8:0]  rom_data;
  logic [9:0]  pin_word;

  // Odd quadrants walk the table backwards; 127-i is simply the 7-bit complement.
  assign quadrant = n_reg[8:7];
  assign rom_addr = quadrant[0] ? ~n_reg[6:0] : n_reg[6:0];
  assign rom_data = QUARTER_ROM[rom_addr];

  always_comb begin
    div_next = div_reg + 16'd1;
    n_next   = n_reg;
    if (div_reg == DIV_LAST) begin
      div_next = 16'd0;
      n_next   = n_reg + N_STEP;
    end
    // Upper half is 512+Q, lower half is 511-Q == 9-bit complement of Q with MSB clear.
    dac_next = quadrant[1] ? {1'b0, ~rom_data} : {1'b1, rom_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= 16'd0;
      n_reg   <= 9'd0;
      dac_reg <= 10'd512;
    end else begin
      div_reg <= div_next;
      n_reg   <= n_next;
      dac_reg <= dac_next;
    end
  end

  for (genvar gi = 0; gi < 10; gi++) begin : g_pin
`ifdef MP3_OUTPUT_INVERT_EN
    assign pin_word[gi] = ~dac_reg[gi];
`else
    assign pin_word[gi] = dac_reg[gi];
`endif
  end

  assign _9b  = pin_word[9];
  assign _6a  = pin_word[8];
  assign _4a  = pin_word[7];
  assign _2a  = pin_word[6];
  assign _0a  = pin_word[5];
  assign _5a  = pin_word[4];
  assign _3b  = pin_word[3];
  assign _49a = pin_word[2];
  assign _45a = pin_word[1];
  assign _48b = pin_word[0];

endmodule

// File: tb/tb_mp3_sine_gen.sv
// Directed bench for mp3_sine_gen: default build, a SAMPLE_DIV=4 build and a PHASE_INC=64 build side by side.
module tb_mp3_sine_gen;

  logic       clk;
  logic       rst_n;
  logic [9:0] w_def, w_div4, w_inc64;
  logic [9:0] hist [512];

  int n_checks = 0;
  int n_pass   = 0;

  // Hand-tabulated floor(512*sin(pi*(2i+1)/512)), capped at 511.
  int q_tab [128] = '{
    3,   9,   15,  21,  28,  34,  40,  47,  53,  59,  65,  72,  78,  84,  90,  96,
    102, 109, 115, 121, 127, 133, 139, 145, 151, 157, 163, 169, 175, 181, 187, 193,
    198, 204, 210, 216, 221, 227, 233, 238, 244, 249, 255, 260, 265, 271, 276, 281,
    287, 292, 297, 302, 307, 312, 317, 322, 327, 332, 336, 341, 346, 350, 355, 359,
    364, 368, 372, 377, 381, 385, 389, 393, 397, 401, 405, 409, 413, 416, 420, 423,
    427, 430, 434, 437, 440, 443, 447, 450, 453, 455, 458, 461, 464, 466, 469, 471,
    474, 476, 478, 481, 483, 485, 487, 489, 490, 492, 494, 495, 497, 498, 500, 501,
    502, 503, 504, 505, 506, 507, 508, 509, 509, 510, 510, 511, 511, 511, 511, 511
  };

  // Inc-64 walk visits n = 0,64,...,448: 512+Q[0], 512+Q[64], 512+Q[127], 512+Q[63], 511-Q[0], ...
  int inc64_seq [8] = '{515, 876, 1023, 871, 508, 147, 0, 152};

  mp3_sine_gen dut (
    .clk(clk), .rst_n(rst_n),
    ._9b(w_def[9]), ._6a(w_def[8]), ._4a(w_def[7]), ._2a(w_def[6]), ._0a(w_def[5]),
    ._5a(w_def[4]), ._3b(w_def[3]), ._49a(w_def[2]), ._45a(w_def[1]), ._48b(w_def[0])
  );

  mp3_sine_gen #(.SAMPLE_DIV(4)) dut_div4 (
    .clk(clk), .rst_n(rst_n),
    ._9b(w_div4[9]), ._6a(w_div4[8]), ._4a(w_div4[7]), ._2a(w_div4[6]), ._0a(w_div4[5]),
    ._5a(w_div4[4]), ._3b(w_div4[3]), ._49a(w_div4[2]), ._45a(w_div4[1]), ._48b(w_div4[0])
  );

  mp3_sine_gen #(.PHASE_INC(64)) dut_inc64 (
    .clk(clk), .rst_n(rst_n),
    ._9b(w_inc64[9]), ._6a(w_inc64[8]), ._4a(w_inc64[7]), ._2a(w_inc64[6]), ._0a(w_inc64[5]),
    ._5a(w_inc64[4]), ._3b(w_inc64[3]), ._49a(w_inc64[2]), ._45a(w_inc64[1]), ._48b(w_inc64[0])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int f_of(input int n);
    int q, i, idx;
    q   = (n % 512) / 128;
    i   = n % 128;
    idx = (q % 2 == 1) ? (127 - i) : i;
    return (q >= 2) ? (511 - q_tab[idx]) : (512 + q_tab[idx]);
  endfunction

  function automatic int pin_of(input int v);
`ifdef MP3_OUTPUT_INVERT_EN
    return 1023 - v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
      $display("ok   %s got=%0d", tag, got);
    end else begin
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_def",   int'(w_def),   pin_of(512));
    check("reset_div4",  int'(w_div4),  pin_of(512));
    check("reset_inc64", int'(w_inc64), pin_of(512));

    rst_n = 1'b1;
    for (int j = 1; j <= 1250; j++) begin
      @(negedge clk);
      check($sformatf("def[%0d]", j), int'(w_def), pin_of(f_of(j - 1)));
      if (j <= 512) hist[j - 1] = w_def;
      if (j == 1)   check("first_edge",   int'(w_def), pin_of(515));
      if (j == 2)   check("second_edge",  int'(w_def), pin_of(521));
      if (j == 128) check("peak_n127",    int'(w_def), pin_of(1023));
      if (j == 256) check("f255",         int'(w_def), pin_of(515));
      if (j == 257) check("f256",         int'(w_def), pin_of(508));
      if (j == 512) check("f511",         int'(w_def), pin_of(508));
      if (j == 513) check("wrap_to_f0",   int'(w_def), pin_of(515));
      if (j <= 8)
        check($sformatf("div4[%0d]", j), int'(w_div4), pin_of((j <= 4) ? 515 : 521));
      else if (j <= 64)
        check($sformatf("div4[%0d]", j), int'(w_div4), pin_of(f_of((j - 1) / 4)));
      if (j <= 16)
        check($sformatf("inc64[%0d]", j), int'(w_inc64), pin_of(inc64_seq[(j - 1) % 8]));
    end

    for (int k = 0; k < 256; k++)
      check($sformatf("sym[%0d]", k), int'(hist[k]) + int'(hist[k + 256]), 1023);

    // Mid-cycle reset must reach the pins without waiting for a clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_def",  int'(w_def),  pin_of(512));
    check("async_rst_div4", int'(w_div4), pin_of(512));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_def",   int'(w_def),   pin_of(515));
    check("restart_inc64", int'(w_inc64), pin_of(515));
    @(negedge clk);
    check("restart_def2",  int'(w_def),   pin_of(521));
    check("restart_inc64b", int'(w_inc64), pin_of(876));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mp3_sine_gen.md
Name: mp3_sine_gen

Overview:
- Free-running sine-wave generator driving a 10-bit parallel resistor-ladder DAC through ten individually named FPGA pins.
- Steps a 9-bit phase index through a 512-sample period.
- Reconstructs each sample from a 128-entry quarter-wave ROM using quadrant symmetry.
- Top-level board block; no input besides clock and reset.

Parameters:
- SAMPLE_DIV, default 1: clock cycles per phase step; legal range 1..65535.
- PHASE_INC, default 1: phase-index increment per step, modulo 512; legal range 1..511.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- _9b  output  1  DAC bit 9 (MSB).
- _6a  output  1  DAC bit 8.
- _4a  output  1  DAC bit 7.
- _2a  output  1  DAC bit 6.
- _0a  output  1  DAC bit 5.
- _5a  output  1  DAC bit 4.
- _3b  output  1  DAC bit 3.
- _49a  output  1  DAC bit 2.
- _45a  output  1  DAC bit 1.
- _48b  output  1  DAC bit 0 (LSB).

Behaviour:
- Clock and reset: single clock domain, clk. rst_n is asynchronous and active-low.
- State: divider counter div (16 bit), phase index n (9 bit), output register dac (10 bit). The ten pins are driven directly from dac.
- Reset (rst_n=0, asynchronous): div=0, n=0, dac=512 (midscale, 10'b10_0000_0000). Holds while low; takes effect immediately, including mid-period.
- ROM contents: Q[i] = min(511, floor(512*sin(pi*(2i+1)/512))) for i=0..127, 9-bit unsigned.
  - Q[0]=3, Q[1]=9, Q[127]=511.
  - ROM is combinational or synthesised as LUT/BRAM. Any read latency must be hidden so the timing below holds exactly.
- Quadrant decode: q=n[8:7], i=n[6:0].
  - q=0: f(n) = 512 + Q[i]
  - q=1: f(n) = 512 + Q[127-i]
  - q=2: f(n) = 511 - Q[i]
  - q=3: f(n) = 511 - Q[127-i]
  - Resulting range is 0..1023, odd-symmetric about 511.5.
- Each rising edge with rst_n=1:
  - dac <= f(n), where n is the value before the edge (1-cycle latency from n to pins).
  - If div == SAMPLE_DIV-1: div <= 0 and n <= (n + PHASE_INC) mod 512. Otherwise div <= div+1.
- Wrap-around: n wraps 511 -> 0 with no glitch or extra cycle. With PHASE_INC=1 the period is exactly 512*SAMPLE_DIV clocks.
- First edge after reset release: dac = f(0) = 515.
- All ten outputs change on the same clock edge. No combinational path from any input to the outputs other than the async reset.

Optional Feature:
- Macro: MP3_OUTPUT_INVERT_EN.
- Defined: the pins carry the bitwise complement of dac, for an inverting ladder buffer. The reset value seen on the pins is 511, and all sample values on the pins become 1023 - f(n).
- Undefined: pins equal dac exactly as specified above.
- Internal state and timing are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> pins read 512. Drop rst_n asynchronously between edges -> pins return to 512 immediately, without waiting for an edge.
- Startup sequence, defaults: release reset -> pins give 515, 521 on the first two edges, then f(2), f(3), ... With n=127 as the input, the pins show 1023 one edge later.
- Quadrant symmetry, defaults: for every k in 0..255, f(k) + f(k+256) = 1023. Also f(255) = 515 and f(256) = 508.
- Period and wrap, defaults: sample 1250 cycles -> the pin word sequence repeats with period exactly 512, and the step following 1023 - Q[0] = 508 - 0... i.e. f(511)=508 is followed by 515.
- Divider: SAMPLE_DIV=4 -> each value is held exactly 4 clocks. First 8 values after reset: 515,515,515,515,521,521,521,521.
- Optional feature: build with MP3_OUTPUT_INVERT_EN -> reset shows 511, first edge shows 508. Build without it -> reset shows 512, first edge shows 515.
